// File: rtl/axis_strip_pkg.sv
// Shared definitions for the AXI-Stream head/end strip block: FSM state
// encoding and counter width.
package axis_strip_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    PASS = 2'd2
  } strip_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register. It loads when load_i is high and
// otherwise empties once the downstream side has taken the beat.
module axis_out_reg #(
  parameter int DSIZE = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DSIZE-1:0] load_data_i,
  input  logic             load_last_i,
  input  logic             tready_i,
  output logic             tvalid_o,
  output logic [DSIZE-1:0] tdata_o,
  output logic             tlast_o,
  output logic             free_o
);

  logic             tvalid_q;
  logic [DSIZE-1:0] tdata_q;
  logic             tlast_q;

  // Data and last stay stable while valid is held, so an unaccepted beat
  // keeps its payload.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else if (load_i) begin
      tvalid_q <= 1'b1;
      tdata_q  <= load_data_i;
      tlast_q  <= load_last_i;
    end else if (tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

  assign tvalid_o = tvalid_q;
  assign tdata_o  = tdata_q;
  assign tlast_o  = tlast_q;
  assign free_o   = !tvalid_q || tready_i;

endmodule

// File: rtl/axis_strip_a1.sv
// AXI-Stream de-framer: removes the head and end beats of each packet and
// moves tlast onto the new final beat. Packet counters are built only when
// AXIS_STRIP_A1_CNT_EN is defined.
module axis_strip_a1
  import axis_strip_pkg::*;
#(
  parameter int DSIZE = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic [DSIZE-1:0] in_tdata,
  input  logic             in_tvalid,
  input  logic             in_tlast,
  output logic             in_tready,
  output logic [DSIZE-1:0] out_tdata,
  output logic             out_tvalid,
  output logic             out_tlast,
  input  logic             out_tready,
  output logic [DSIZE-1:0] head_value,
  output logic             head_vld,
  output logic [DSIZE-1:0] end_value,
  output logic             end_vld,
  output logic             short_pkt,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      short_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a beat moves on both sides only when valid and ready are high
  // on the same rising edge; valid never waits for ready, and a presented beat
  // stays unchanged until it is taken.
  strip_state_e     state_q, state_d;
  logic [DSIZE-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [DSIZE-1:0] head_q, head_d, end_q, end_d;
  logic             head_vld_q, head_vld_d, end_vld_q, end_vld_d;
  logic             short_q, short_d;
  logic             ld, ld_last, out_free;
  logic [DSIZE-1:0] ld_data;
  logic             accept;

  assign in_tready = out_free;
  assign accept    = in_tvalid && in_tready;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    ld         = 1'b0;
    ld_data    = in_tdata;
    ld_last    = in_tlast;
    head_d     = head_q;
    head_vld_d = 1'b0;
    end_d      = end_q;
    end_vld_d  = 1'b0;
    short_d    = 1'b0;
    if (accept) begin
      case (state_q)
        HEAD: begin
          if (!enable) begin
            ld = 1'b1;
            if (!in_tlast) state_d = PASS;
          end else begin
            head_d     = in_tdata;
            head_vld_d = 1'b1;
            if (in_tlast) short_d = 1'b1;
            else          state_d = BODY;
          end
        end
        PASS: begin
          ld = 1'b1;
          if (in_tlast) state_d = HEAD;
        end
        BODY: begin
          // The hold register lags one beat so the final payload beat is
          // already known when the end word arrives.
          if (!in_tlast) begin
            if (hold_v_q) begin
              ld      = 1'b1;
              ld_data = hold_q;
              ld_last = 1'b0;
            end
            hold_d   = in_tdata;
            hold_v_d = 1'b1;
          end else begin
            end_d     = in_tdata;
            end_vld_d = 1'b1;
            if (hold_v_q) begin
              ld      = 1'b1;
              ld_data = hold_q;
              ld_last = 1'b1;
            end else begin
              short_d = 1'b1;
            end
            hold_v_d = 1'b0;
            state_d  = HEAD;
          end
        end
        default: state_d = HEAD;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= HEAD;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      end_q      <= '0;
      end_vld_q  <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      end_q      <= end_d;
      end_vld_q  <= end_vld_d;
      short_q    <= short_d;
    end
  end

  axis_out_reg #(.DSIZE(DSIZE)) u_out_reg (
    .clock       (clock),
    .rst         (rst),
    .load_i      (ld),
    .load_data_i (ld_data),
    .load_last_i (ld_last),
    .tready_i    (out_tready),
    .tvalid_o    (out_tvalid),
    .tdata_o     (out_tdata),
    .tlast_o     (out_tlast),
    .free_o      (out_free)
  );

`ifdef AXIS_STRIP_A1_CNT_EN
  logic [CNT_W-1:0] pkt_cnt_q, short_cnt_q;

  // An end word with no short flag marks a packet that had real payload.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      short_cnt_q <= '0;
    end else begin
      if (end_vld_d && !short_d) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (short_d)               short_cnt_q <= short_cnt_q + 1'b1;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign short_cnt = short_cnt_q;
`else
  assign pkt_cnt   = '0;
  assign short_cnt = '0;
`endif

  assign head_value = head_q;
  assign head_vld   = head_vld_q;
  assign end_value  = end_q;
  assign end_vld    = end_vld_q;
  assign short_pkt  = short_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_axis_strip_a1.sv
// Directed self-checking bench for axis_strip_a1 (counter checks follow
// AXIS_STRIP_A1_CNT_EN).
module tb_axis_strip_a1;

  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] in_tdata = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tlast = 1'b0;
  logic          in_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tlast;
  logic          out_tready = 1'b1;
  logic [DW-1:0] head_value, end_value;
  logic          head_vld, end_vld, short_pkt;
  logic [15:0]   pkt_cnt, short_cnt;
  logic [1:0]    dbg_state;

  always #5 clock = ~clock;

  axis_strip_a1 #(.DSIZE(DW)) dut (
    .clock      (clock),
    .rst        (rst),
    .enable     (enable),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tready (out_tready),
    .head_value (head_value),
    .head_vld   (head_vld),
    .end_value  (end_value),
    .end_vld    (end_vld),
    .short_pkt  (short_pkt),
    .pkt_cnt    (pkt_cnt),
    .short_cnt  (short_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            failures = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] exp_head_q[$];
  logic [DW-1:0] exp_end_q[$];
  int            exp_short = 0;
  int            obs_short = 0;
  int            exp_pkt_cnt = 0;
  int            exp_short_cnt = 0;
  int            cyc = 0;
  int            out_cyc[$];
  logic          toggle_en = 1'b0;
  logic          stall_q = 1'b0;
  logic [DW:0]   stall_val = '0;
  logic [DW:0]   mon_e;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (out_tvalid && out_tready) begin
        out_cyc.push_back(cyc);
        check_eq("out_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("out_beat", 64'({out_tlast, out_tdata}), 64'(mon_e));
        end
      end
      if (stall_q && out_tvalid) check_eq("stall_stable", 64'({out_tlast, out_tdata}), 64'(stall_val));
      stall_q   = out_tvalid && !out_tready;
      stall_val = {out_tlast, out_tdata};
      if (head_vld) begin
        check_eq("head_expected", 64'(exp_head_q.size() > 0), 64'd1);
        if (exp_head_q.size() > 0) check_eq("head_value", 64'(head_value), 64'(exp_head_q.pop_front()));
      end
      if (end_vld) begin
        check_eq("end_expected", 64'(exp_end_q.size() > 0), 64'd1);
        if (exp_end_q.size() > 0) check_eq("end_value", 64'(end_value), 64'(exp_end_q.pop_front()));
      end
      if (short_pkt) obs_short++;
    end
  end

  // Downstream ready pattern, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (toggle_en) out_tready = ~out_tready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [DW-1:0] d, input logic last);
    int   budget;
    logic acc;
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tlast  = last;
    budget    = 0;
    forever begin
      @(negedge clock);
      acc = in_tready;
      @(posedge clock);
      #2;
      if (acc) break;
      budget++;
      if (budget > 100) begin
        check_eq("accept_timeout", 64'(budget), 64'd0);
        break;
      end
    end
  endtask

  task automatic send_pkt(input logic en, input int n, input logic [DW-1:0] base);
    enable = en;
    if (!en) begin
      for (int i = 0; i < n; i++) exp_q.push_back({1'(i == n - 1), base + DW'(i)});
    end else begin
      exp_head_q.push_back(base);
      if (n >= 2) exp_end_q.push_back(base + DW'(n - 1));
      if (n < 3) begin
        exp_short++;
        exp_short_cnt++;
      end else begin
        exp_pkt_cnt++;
        for (int i = 1; i <= n - 2; i++) exp_q.push_back({1'(i == n - 2), base + DW'(i)});
      end
    end
    for (int i = 0; i < n; i++) begin
      drive_beat(base + DW'(i), i == n - 1);
      if (i == 0) enable = ~en;
    end
  endtask

  task automatic go_idle();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && exp_head_q.size() == 0 && exp_end_q.size() == 0) break;
      @(posedge clock);
      #2;
    end
    repeat (3) @(posedge clock);
    #2;
    check_eq("drain", 64'(exp_q.size() + exp_head_q.size() + exp_end_q.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_out_tvalid"}, 64'(out_tvalid), 64'd0);
    check_eq({tag, "_out_tdata"},  64'(out_tdata),  64'd0);
    check_eq({tag, "_out_tlast"},  64'(out_tlast),  64'd0);
    check_eq({tag, "_head_value"}, 64'(head_value), 64'd0);
    check_eq({tag, "_head_vld"},   64'(head_vld),   64'd0);
    check_eq({tag, "_end_value"},  64'(end_value),  64'd0);
    check_eq({tag, "_end_vld"},    64'(end_vld),    64'd0);
    check_eq({tag, "_short_pkt"},  64'(short_pkt),  64'd0);
    check_eq({tag, "_pkt_cnt"},    64'(pkt_cnt),    64'd0);
    check_eq({tag, "_short_cnt"},  64'(short_cnt),  64'd0);
    check_eq({tag, "_state"},      64'(dbg_state),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    repeat (3) @(posedge clock);
    #2;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clock);
    #2;

    // 5-beat stripped packet, no back-pressure
    out_cyc.delete();
    send_pkt(1'b1, 5, 32'hA0);
    go_idle();
    wait_drain(50);
    check_eq("t1_head", 64'(head_value), 64'hA0);
    check_eq("t1_end", 64'(end_value), 64'hA4);
    check_eq("t1_beats", 64'(out_cyc.size()), 64'd3);
    if (out_cyc.size() == 3) check_eq("t1_no_bubble", 64'(out_cyc[2] - out_cyc[0]), 64'd2);

    // 3-beat pass-through packet
    send_pkt(1'b0, 3, 32'hB0);
    go_idle();
    wait_drain(50);
    check_eq("t2_head_kept", 64'(head_value), 64'hA0);
    check_eq("t2_end_kept", 64'(end_value), 64'hA4);

    // 2-beat stripped packet
    send_pkt(1'b1, 2, 32'hC0);
    go_idle();
    wait_drain(50);
    check_eq("t3_head", 64'(head_value), 64'hC0);
    check_eq("t3_end", 64'(end_value), 64'hC1);
    check_eq("t3_short", 64'(obs_short), 64'(exp_short));

    // 1-beat packet, then the next beat must be taken as a head
    send_pkt(1'b1, 1, 32'hD0);
    send_pkt(1'b1, 3, 32'hD8);
    go_idle();
    wait_drain(50);
    check_eq("t4_head", 64'(head_value), 64'hD8);
    check_eq("t4_end", 64'(end_value), 64'hDA);
    check_eq("t4_short", 64'(obs_short), 64'(exp_short));

    // reset after beat 3 of a 6-beat packet
    enable = 1'b1;
    exp_head_q.push_back(32'h50);
    drive_beat(32'h50, 1'b0);
    drive_beat(32'h51, 1'b0);
    drive_beat(32'h52, 1'b0);
    go_idle();
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    exp_pkt_cnt   = 0;
    exp_short_cnt = 0;
    @(posedge clock);
    #2;
    rst = 1'b0;
    send_pkt(1'b1, 4, 32'hE0);
    go_idle();
    wait_drain(50);
    check_eq("t5_head", 64'(head_value), 64'hE0);
    check_eq("t5_end", 64'(end_value), 64'hE3);

    // four back-to-back 6-beat packets with toggling downstream ready
    toggle_en = 1'b1;
    for (int k = 0; k < 4; k++) send_pkt(1'b1, 6, 32'h100 + DW'(k * 16));
    go_idle();
    wait_drain(200);
    toggle_en  = 1'b0;
    out_tready = 1'b1;
    check_eq("t6_end", 64'(end_value), 64'h135);

    check_eq("short_total", 64'(obs_short), 64'(exp_short));
`ifdef AXIS_STRIP_A1_CNT_EN
    check_eq("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));
    check_eq("short_cnt", 64'(short_cnt), 64'(exp_short_cnt));
`else
    check_eq("pkt_cnt_tied", 64'(pkt_cnt), 64'd0);
    check_eq("short_cnt_tied", 64'(short_cnt), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
